// File: rtl/riscv_aes_result_writeback.sv
`default_nettype none
// ============================================================================
// Module      : riscv_aes_result_writeback
// Description : Stores one AES result to data memory as NUM_WORDS consecutive
//               32-bit writes over an OBI-style req/gnt/rvalid port. Only one
//               transaction is outstanding at a time. done_o pulses when the
//               last write response returns. err_o is sticky per result.
// Config      : AES_WB_BYTESWAP_EN - drive each store word byte-reversed
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_aes_result_writeback #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_WORDS  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            res_valid_i,
   input  logic [NUM_WORDS*DATA_WIDTH-1:0] res_data_i,
   output logic                            res_ready_o,
   input  logic [ADDR_WIDTH-1:0]           wb_addr_i,
   output logic                            data_req_o,
   input  logic                            data_gnt_i,
   input  logic                            data_rvalid_i,
   input  logic                            data_err_i,
   output logic [ADDR_WIDTH-1:0]           data_addr_o,
   output logic                            data_we_o,
   output logic [3:0]                      data_be_o,
   output logic [DATA_WIDTH-1:0]           data_wdata_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o
);

   localparam int            KW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [KW-1:0] LAST_K = KW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                          state_q, state_d;
   // The result register shifts down one word per completed write, so the
   // word to store is always the lowest DATA_WIDTH bits.
   logic [NUM_WORDS*DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
   logic [KW-1:0]                   k_q, k_d;
   logic                            err_q, err_d;
   logic [DATA_WIDTH-1:0]           word_w;
   logic                            req_w;

   // State and datapath registers; reset aborts any transfer immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         addr_q  <= '0;
         k_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         k_q     <= k_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: accept, request until granted, await response, repeat.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      addr_d  = addr_q;
      k_d     = k_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (res_valid_i) begin
               data_d  = res_data_i;
               // Base is forced word-aligned; low address bits are dropped.
               addr_d  = wb_addr_i & ~ADDR_WIDTH'(3);
               k_d     = '0;
               err_d   = 1'b0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (data_gnt_i) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            // A response in the grant cycle is never seen here, since the
            // FSM only enters RESP on the edge that ends the grant cycle.
            if (data_rvalid_i) begin
               err_d = err_q | data_err_i;
               if (k_q == LAST_K) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + KW'(1);
                  addr_d  = addr_q + ADDR_WIDTH'(4);
                  data_d  = data_q >> DATA_WIDTH;
                  state_d = S_REQ;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef AES_WB_BYTESWAP_EN
   // Big-endian AES state layout: reverse bytes within each word.
   assign word_w = {data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};
`else
   assign word_w = data_q[DATA_WIDTH-1:0];
`endif

   assign req_w        = (state_q == S_REQ);
   assign res_ready_o  = (state_q == S_IDLE) && !rst;
   assign data_req_o   = req_w;
   assign data_we_o    = req_w;
   assign data_be_o    = req_w ? 4'hF : 4'h0;
   assign data_addr_o  = req_w ? addr_q : '0;
   assign data_wdata_o = req_w ? word_w : '0;
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
   assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_aes_result_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_aes_result_writeback
// Description : Randomized self-checking bench for riscv_aes_result_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_aes_result_writeback;

   logic         clk;
   logic         rst;
   logic         res_valid_i;
   logic [127:0] res_data_i;
   logic         res_ready_o;
   logic [31:0]  wb_addr_i;
   logic         data_req_o;
   logic         data_gnt_i;
   logic         data_rvalid_i;
   logic         data_err_i;
   logic [31:0]  data_addr_o;
   logic         data_we_o;
   logic [3:0]   data_be_o;
   logic [31:0]  data_wdata_o;
   logic         busy_o;
   logic         done_o;
   logic         err_o;

   int total = 0;
   int bad   = 0;
   int g_st[4];
   int r_st[4];

   riscv_aes_result_writeback #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .NUM_WORDS (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .res_valid_i  (res_valid_i),
      .res_data_i   (res_data_i),
      .res_ready_o  (res_ready_o),
      .wb_addr_i    (wb_addr_i),
      .data_req_o   (data_req_o),
      .data_gnt_i   (data_gnt_i),
      .data_rvalid_i(data_rvalid_i),
      .data_err_i   (data_err_i),
      .data_addr_o  (data_addr_o),
      .data_we_o    (data_we_o),
      .data_be_o    (data_be_o),
      .data_wdata_o (data_wdata_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected memory image of word w of a result.
   function automatic logic [31:0] exp_word(input logic [127:0] res, input int w);
      logic [31:0] v;
      v = res[32*w +: 32];
`ifdef AES_WB_BYTESWAP_EN
      v = {v[7:0], v[15:8], v[23:16], v[31:24]};
`endif
      return v;
   endfunction

   // Request-phase checks for one word.
   task automatic check_req(input logic [31:0] a, input logic [31:0] d);
      check("req",   data_req_o, 1'b1);
      check("addr",  data_addr_o, a);
      check("wdata", data_wdata_o, d);
      check("we",    data_we_o, 1'b1);
      check("be",    data_be_o, 4'hF);
      check("done_mid", done_o, 1'b0);
   endtask

   // One full result transfer; stalls come from g_st/r_st. Called 1 time
   // unit after a rising edge with the DUT in IDLE.
   task automatic run_result(input logic [31:0] base, input logic [127:0] res, input logic [3:0] emask);
      logic [31:0] a;
      res_valid_i = 1'b1;
      wb_addr_i   = base;
      res_data_i  = res;
      @(negedge clk);
      check("ready_idle", res_ready_o, 1'b1);
      check("busy_idle",  busy_o, 1'b0);
      @(posedge clk); #1;
      res_valid_i = 1'b0;
      // Inputs changing after acceptance must not matter.
      wb_addr_i   = $urandom;
      res_data_i  = {$urandom, $urandom, $urandom, $urandom};
      for (int w = 0; w < 4; w++) begin
         a = (base & 32'hFFFF_FFFC) + 32'(4 * w);
         for (int i = 0; i < g_st[w]; i++) begin
            data_gnt_i = 1'b0;
            @(negedge clk);
            check_req(a, exp_word(res, w));
            @(posedge clk); #1;
         end
         data_gnt_i    = 1'b1;
         // A response in the grant cycle must be ignored.
         data_rvalid_i = 1'($urandom_range(0, 1));
         data_err_i    = 1'b1;
         @(negedge clk);
         check_req(a, exp_word(res, w));
         @(posedge clk); #1;
         data_gnt_i    = 1'b0;
         data_rvalid_i = 1'b0;
         data_err_i    = 1'($urandom_range(0, 1));
         for (int i = 0; i < r_st[w]; i++) begin
            @(negedge clk);
            check("req_resp", data_req_o, 1'b0);
            check("busy_resp", busy_o, 1'b1);
            check("done_mid", done_o, 1'b0);
            @(posedge clk); #1;
         end
         data_rvalid_i = 1'b1;
         data_err_i    = emask[w];
         @(negedge clk);
         check("req_resp", data_req_o, 1'b0);
         check("ready_busy", res_ready_o, 1'b0);
         @(posedge clk); #1;
         data_rvalid_i = 1'b0;
         data_err_i    = 1'b0;
      end
      @(negedge clk);
      check("done", done_o, 1'b1);
      check("busy_done", busy_o, 1'b1);
      check("ready_done", res_ready_o, 1'b0);
      check("err_done", err_o, |emask);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_after", done_o, 1'b0);
      check("busy_after", busy_o, 1'b0);
      check("err_sticky", err_o, |emask);
      check("ready_after", res_ready_o, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic no_stalls();
      for (int i = 0; i < 4; i++) begin
         g_st[i] = 0;
         r_st[i] = 0;
      end
   endtask

   initial begin
      rst           = 1'b1;
      res_valid_i   = 1'b0;
      res_data_i    = '0;
      wb_addr_i     = '0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_err_i    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", res_ready_o, 1'b0);
      check("rst_req",   data_req_o, 1'b0);
      check("rst_we",    data_we_o, 1'b0);
      check("rst_be",    data_be_o, 4'h0);
      check("rst_addr",  data_addr_o, 32'h0);
      check("rst_wdata", data_wdata_o, 32'h0);
      check("rst_busy",  busy_o, 1'b0);
      check("rst_done",  done_o, 1'b0);
      check("rst_err",   err_o, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Minimum-latency transfer.
      no_stalls();
      run_result(32'h0000_1000, 128'h33333333_22222222_11111111_00000000, 4'b0000);
      // Grant withheld three cycles on word 2.
      g_st[2] = 3;
      run_result(32'h0000_1000, 128'h33333333_22222222_11111111_00000000, 4'b0000);
      // Address wrap and unaligned base.
      no_stalls();
      run_result(32'hFFFF_FFF8, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 4'b0000);
      run_result(32'h0000_1003, 128'h44444444_55555555_66666666_77777777, 4'b0000);
      // Error on word 1 only, then cleared by the next result.
      run_result(32'h0000_2000, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 4'b0010);
      run_result(32'h0000_3000, 128'h0, 4'b0000);

      // Reset while waiting for the response of word 1.
      res_valid_i = 1'b1;
      wb_addr_i   = 32'h0000_4000;
      res_data_i  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      @(posedge clk); #1;
      res_valid_i = 1'b0;
      data_gnt_i  = 1'b1;
      @(negedge clk);
`ifdef AES_WB_BYTESWAP_EN
      check("bswap_w0", data_wdata_o, 32'h0001_0203);
`else
      check("bswap_w0", data_wdata_o, 32'h0302_0100);
`endif
      @(posedge clk); #1;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      @(posedge clk); #1;
      data_rvalid_i = 1'b0;
      data_gnt_i    = 1'b1;
      @(negedge clk);
      check("rst_pre_addr", data_addr_o, 32'h0000_4004);
      @(posedge clk); #1;
      data_gnt_i = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", res_ready_o, 1'b0);
      check("rst_mid_req",   data_req_o, 1'b0);
      check("rst_mid_addr",  data_addr_o, 32'h0);
      check("rst_mid_wdata", data_wdata_o, 32'h0);
      check("rst_mid_be",    data_be_o, 4'h0);
      check("rst_mid_busy",  busy_o, 1'b0);
      check("rst_mid_done",  done_o, 1'b0);
      @(posedge clk); #1;
      rst           = 1'b0;
      data_rvalid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_done", done_o, 1'b0);
         check("rst_no_busy", busy_o, 1'b0);
         @(posedge clk); #1;
         data_rvalid_i = 1'b0;
      end
      run_result(32'h0000_4000, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 4'b0000);

      // Randomized results with random stalls and error patterns.
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 4; i++) begin
            g_st[i] = $urandom_range(0, 3);
            r_st[i] = $urandom_range(0, 3);
         end
         run_result($urandom, {$urandom, $urandom, $urandom, $urandom},
                    4'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
